// File: rtl/rx_slip_scheduler_if.sv
// Slip command bundle between the lane block-sync engines and the slip scheduler.
// The block-sync side is the master. The scheduler is the slave.
interface rx_slip_scheduler_if #(
    parameter int LANES = 4
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0] slip_req;
    logic [LANES-1:0] lane_locked;
    logic             slip_valid;
    logic [LW-1:0]    slip_lane;
    logic [LANES-1:0] lane_reset;
    logic             all_locked;
    logic [7:0]       reset_events;

    modport master (
        output slip_req, lane_locked,
        input  slip_valid, slip_lane, lane_reset, all_locked, reset_events
    );

    modport slave (
        input  slip_req, lane_locked,
        output slip_valid, slip_lane, lane_reset, all_locked, reset_events
    );
endinterface

// File: rtl/rx_slip_scheduler.sv
// Per-lane bitslip sequencer: latches slip requests and grants one gearbox slip per cycle, round-robin.
// Each slip is followed by a hold-off. A lane that exhausts its slip budget without locking is reset.
module rx_slip_scheduler #(
    parameter int LANES        = 4,
    parameter int SLIP_HOLDOFF = 4,
    parameter int SLIP_LIMIT   = 132,
    parameter int RESET_CYCLES = 16
) (
    input logic               clk,
    input logic               reset,
    rx_slip_scheduler_if.slave bus
);
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW   = $clog2(SLIP_LIMIT + 1);
    localparam int TMAX = (SLIP_HOLDOFF > RESET_CYCLES) ? SLIP_HOLDOFF : RESET_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {SEARCH, HOLD, LOCKED, LRESET} lane_state_t;

    lane_state_t      state_q [LANES];
    lane_state_t      state_d [LANES];
    logic [CW-1:0]    cnt_q   [LANES];
    logic [CW-1:0]    cnt_d   [LANES];
    logic [TW-1:0]    tmr_q   [LANES];
    logic [TW-1:0]    tmr_d   [LANES];
    logic [LANES-1:0] pend_q, pend_d;
    logic [LW-1:0]    ptr_q, ptr_d;
    logic [7:0]       events_q, events_d;

    logic [LANES-1:0] elig, gnt, locked_now;
    logic             grant_any;
    logic [LW-1:0]    grant_idx;

    logic             slip_valid_q;
    logic [LW-1:0]    slip_lane_q;
    logic [LANES-1:0] lane_reset_q;
    logic             all_locked_q;

    // A lane whose lock arrives this cycle drops out of eligibility, so the grant moves on.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        elig      = '0;
        gnt       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            elig[i] = (state_q[i] == SEARCH) && pend_q[i] && !bus.lane_locked[i];
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            idx = (32'(ptr_q) + k) % LANES;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx[LW-1:0];
                gnt[idx]  = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == LW'(LANES - 1)) ? '0 : grant_idx + LW'(1);
        end
    end

    always_comb begin
        pend_d     = pend_q;
        events_d   = events_q;
        locked_now = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            tmr_d[i]      = tmr_q[i];
            locked_now[i] = (state_q[i] == LOCKED);
            case (state_q[i])
                SEARCH: begin
                    if (bus.lane_locked[i]) begin
                        state_d[i] = LOCKED;
                        pend_d[i]  = 1'b0;
                        cnt_d[i]   = '0;
                    end else if (gnt[i]) begin
                        state_d[i] = HOLD;
                        pend_d[i]  = 1'b0;
                        cnt_d[i]   = cnt_q[i] + CW'(1);
                        tmr_d[i]   = TW'(SLIP_HOLDOFF - 1);
                    end else if (bus.slip_req[i]) begin
                        pend_d[i]  = 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr_q[i] == '0) begin
                        if (cnt_q[i] == CW'(SLIP_LIMIT)) begin
                            state_d[i] = LRESET;
                            tmr_d[i]   = TW'(RESET_CYCLES - 1);
                            cnt_d[i]   = '0;
                            if (events_d != 8'hFF) begin
                                events_d = events_d + 8'd1;
                            end
                        end else begin
                            state_d[i] = SEARCH;
                        end
                    end else begin
                        tmr_d[i] = tmr_q[i] - TW'(1);
                    end
                end
                LOCKED: begin
                    pend_d[i] = 1'b0;
                    if (!bus.lane_locked[i]) begin
                        state_d[i] = SEARCH;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    pend_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                    if (tmr_q[i] == '0) begin
                        state_d[i] = SEARCH;
                    end else begin
                        tmr_d[i] = tmr_q[i] - TW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                state_q[i] <= SEARCH;
                cnt_q[i]   <= '0;
                tmr_q[i]   <= '0;
            end
            pend_q       <= '0;
            ptr_q        <= '0;
            events_q     <= '0;
            slip_valid_q <= 1'b0;
            slip_lane_q  <= '0;
            lane_reset_q <= '0;
            all_locked_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                state_q[i]      <= state_d[i];
                cnt_q[i]        <= cnt_d[i];
                tmr_q[i]        <= tmr_d[i];
                lane_reset_q[i] <= (state_d[i] == LRESET);
            end
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            events_q     <= events_d;
            slip_valid_q <= grant_any;
            slip_lane_q  <= grant_idx;
            all_locked_q <= &locked_now;
        end
    end

    assign bus.slip_valid   = slip_valid_q;
    assign bus.slip_lane    = slip_lane_q;
    assign bus.lane_reset   = lane_reset_q;
    assign bus.all_locked   = all_locked_q;
    assign bus.reset_events = events_q;
endmodule

// File: doc/rx_slip_scheduler.md
# rx_slip_scheduler

Per-lane bitslip sequencer for the 40GbE RX PCS. It sits between the four lane block-sync engines and the shared RX gearbox slip command port. It latches each lane's slip requests and grants one gearbox slip per cycle, round-robin. After each slip it enforces a hold-off while the shifted data settles, and it resets any lane that fails to lock within a bounded number of slips. It also reports aggregate lane lock.

## Interface
- LANES, 4, number of PCS lanes (≥2)
- SLIP_HOLDOFF, 4, cycles a lane ignores slip_req and lane_locked after its slip is issued (≥1)
- SLIP_LIMIT, 132, slips a lane may take without locking before it is reset (2 × 66 positions)
- RESET_CYCLES, 16, lane_reset pulse length (≥1)

Ports:
- clk  in  1  PCS RX clock; single clock domain
- reset  in  1  synchronous, active-high
- slip_req  in  LANES  per-lane bitslip request from block sync (pulse or level)
- lane_locked  in  LANES  per-lane block_locked from block sync
- slip_valid  out  1  registered; one gearbox slip command this cycle
- slip_lane  out  max(1,$clog2(LANES))  registered; lane index for slip_valid, 0 when idle
- lane_reset  out  LANES  registered; resets that lane's gearbox and block sync
- all_locked  out  1  registered; every lane in LOCKED
- reset_events  out  8  saturating count of LRESET entries, all lanes

## Operation
- Per-lane FSM states: SEARCH, HOLD, LOCKED, LRESET. Per-lane registers:
  - pending bit
  - slip_cnt, $clog2(SLIP_LIMIT+1) bits
  - hold/reset down-counter
- SEARCH:
  - lane_locked=1 → LOCKED. Clears pending and slip_cnt.
  - Otherwise slip_req=1 sets pending. A request while pending is already set merges into it and is not counted twice.
  - When the lane is granted: pending←0, slip_cnt+1, counter←SLIP_HOLDOFF−1, → HOLD.
- HOLD:
  - slip_req and lane_locked are ignored.
  - Counter decrements each cycle. At 0: if slip_cnt==SLIP_LIMIT → LRESET with counter←RESET_CYCLES−1; else → SEARCH.
- LOCKED:
  - slip_req is ignored. pending stays 0.
  - lane_locked=0 → SEARCH with slip_cnt←0.
- LRESET:
  - lane_reset=1 for exactly RESET_CYCLES cycles; then → SEARCH.
  - slip_cnt←0. pending forced 0.
  - reset_events increments on entry and saturates at 255.
- Arbiter:
  - Requesters are lanes with pending=1 in SEARCH.
  - Round-robin priority pointer starts at lane 0 after reset. After a grant it moves to granted lane+1, mod LANES.
  - At most one grant per cycle. Losing lanes keep pending.
- Simultaneous events in SEARCH:
  - lane_locked and slip_req in the same cycle: lock wins, no pending is set.
  - lane_locked and a grant to that lane in the same cycle: lock wins, no slip is issued, and the arbiter grants the next eligible lane instead.
- all_locked is the registered AND of (state==LOCKED) across lanes.

## Timing
- Reset values:
  - all lanes SEARCH, pending=0, slip_cnt=0, counters=0
  - slip_valid=0, slip_lane=0, lane_reset=0, all_locked=0, reset_events=0, pointer=0
- Reset mid-operation aborts any HOLD or LRESET. lane_reset drops on the cycle after reset is sampled.
- Latency with no contention: slip_req sampled at edge 0 → pending=1 after edge 0 → slip_valid=1 and slip_lane valid after edge 1. The lane enters HOLD on that same edge 1.
- slip_valid is a single-cycle pulse per grant. Back-to-back grants to different lanes on consecutive cycles are allowed.
- The same lane cannot receive another slip for SLIP_HOLDOFF cycles after its slip_valid, plus 2 cycles for the request-to-grant path.
- Lock reporting: a lane state change is reflected in all_locked one cycle later.
- LRESET: lane_reset rises on the edge that enters LRESET and stays high for exactly RESET_CYCLES cycles.

## Test plan
- Single lane: slip_req pulse on lane 2 with other lanes idle → slip_valid=1, slip_lane=2 two cycles later for one cycle. A lane-2 slip_req during the next 4 cycles produces no slip.
- Contention: slip_req held on all 4 lanes from reset → grants in order 0,1,2,3 on consecutive cycles, then repeat 0,1,2,3 once the hold-offs expire.
- Lock path: lane_locked=1 on all lanes → all_locked=1 one cycle after the last lane locks. Drop lane 1 → all_locked=0 one cycle later and lane 1 re-enters SEARCH with slip_cnt=0.
- Timeout: lane 0 with slip_req held high and lane_locked=0 → exactly 132 slips, then lane_reset[0]=1 for 16 cycles and reset_events=1. Slips resume afterwards.
- Collision: lane 3 has pending set and lane_locked[3] rises on the cycle it would be granted → no slip is issued for lane 3, lane 3 goes to LOCKED, and the next pending lane is granted.
- Reset during LRESET (cycle 5 of 16) → lane_reset=0 on the following cycle and all outputs return to their reset values.
